// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority arbiter.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int GNT_CNT_W = 16;

endpackage

// File: rtl/prio_enc_n.sv
// Parametrised combinational priority encoder: highest set index wins.
module prio_enc_n #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan so the highest set bit is the last one kept.
    always_comb begin
        idx = {IDX_W{1'b0}};
        any = |req;
        for (int i = 0; i < N; i++) begin
            idx = req[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-input arbiter, fixed or round-robin priority, valid/ready grant.
// Optional grant counter enabled by defining RR_ARB_GRANT_CNT_EN.
module rr_priority_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    output logic [GNT_CNT_W-1:0] gnt_count
`endif
);

    localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(N - 1);
    localparam logic [N-1:0]     OH_ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0]     gnt_oh_q, gnt_oh_d;

    logic             hs_s;
    logic [IDX_W-1:0] ptr_next_s, sel_ptr_s;
    logic [N-1:0]     mask_s, req_m_s;
    logic [IDX_W-1:0] idx_m_s, idx_u_s, win_idx_s;
    logic             any_m_s, any_u_s;

    // Pointer to search from: on a handshake edge the freshly rotated pointer applies.
    always_comb begin
        hs_s       = (state_q == GRANT) & gnt_ready;
        ptr_next_s = (gnt_idx_q == {IDX_W{1'b0}}) ? PTR_TOP : (gnt_idx_q - IDX_W'(1));
        sel_ptr_s  = hs_s ? ptr_next_s : rr_ptr_q;
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (IDX_W'(i) <= sel_ptr_s) ? 1'b1 : 1'b0;
        end
        req_m_s = req & mask_s;
    end

    prio_enc_n #(.N(N), .IDX_W(IDX_W)) u_enc_masked (
        .req (req_m_s),
        .idx (idx_m_s),
        .any (any_m_s)
    );

    prio_enc_n #(.N(N), .IDX_W(IDX_W)) u_enc_unmasked (
        .req (req),
        .idx (idx_u_s),
        .any (any_u_s)
    );

    // Winner choice; an empty masked search wraps to the unmasked result.
    always_comb begin
        if ((mode == MODE_RR) && any_m_s) begin
            win_idx_s = idx_m_s;
        end else begin
            win_idx_s = idx_u_s;
        end
    end

    // Grant FSM: load on request, hold while stalled, reload or drop on handshake.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_oh_d  = gnt_oh_q;
        case (state_q)
            IDLE: begin
                if (any_u_s) begin
                    state_d   = GRANT;
                    gnt_idx_d = win_idx_s;
                    gnt_oh_d  = OH_ONE << win_idx_s;
                end else begin
                    state_d   = IDLE;
                    gnt_idx_d = {IDX_W{1'b0}};
                    gnt_oh_d  = {N{1'b0}};
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    rr_ptr_d = ptr_next_s;
                    if (any_u_s) begin
                        state_d   = GRANT;
                        gnt_idx_d = win_idx_s;
                        gnt_oh_d  = OH_ONE << win_idx_s;
                    end else begin
                        state_d   = IDLE;
                        gnt_idx_d = {IDX_W{1'b0}};
                        gnt_oh_d  = {N{1'b0}};
                    end
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_idx_d = {IDX_W{1'b0}};
                gnt_oh_d  = {N{1'b0}};
            end
        endcase
    end

    // State, pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= PTR_TOP;
            gnt_idx_q <= {IDX_W{1'b0}};
            gnt_oh_q  <= {N{1'b0}};
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_oh_q  <= gnt_oh_d;
        end
    end

    assign gnt_valid  = (state_q == GRANT);
    assign gnt_idx    = gnt_idx_q;
    assign gnt_onehot = gnt_oh_q;

`ifdef RR_ARB_GRANT_CNT_EN
    logic [GNT_CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;

    // Saturating count of completed handshakes.
    always_comb begin
        if (hs_s && (gnt_cnt_q != {GNT_CNT_W{1'b1}})) begin
            gnt_cnt_d = gnt_cnt_q + GNT_CNT_W'(1);
        end else begin
            gnt_cnt_d = gnt_cnt_q;
        end
    end

    // Handshake counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_q <= {GNT_CNT_W{1'b0}};
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign gnt_count = gnt_cnt_q;
`endif

endmodule
